shared_divider: RTL and testbench

- Iterative unsigned radix-2 restoring divider, shared by the bike computer's arithmetic clients.
- Sits directly downstream of the speed block, which drives dividend and divisor. A second operand channel serves a neighbouring client, for example average speed.
- The top level issues start and steers the operand mux with sel. Clients poll busy and ready to collect the quotient.

---
 rtl/shared_divider.sv | 102 ++++++++++
 tb/tb_shared_divider.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/shared_divider.sv
// Iterative unsigned radix-2 restoring divider shared between two operand channels.
// One quotient bit per cycle; result registers update only on completion.
module shared_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sel,
  input  logic [WIDTH-1:0] dividend_a,
  input  logic [WIDTH-1:0] divisor_a,
  input  logic [WIDTH-1:0] dividend_b,
  input  logic [WIDTH-1:0] divisor_b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             ready,
  output logic             div_zero,
  output logic             owner
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] prem, work, dsr;
  logic [WIDTH-1:0] prem_next, work_next;
  logic [WIDTH:0]   step;
  logic             accept, last;

  // One restoring step: returns {quotient bit, new partial remainder}.
  // The shifted remainder needs WIDTH+1 bits so the trial subtract can borrow.
  function automatic logic [WIDTH:0] trial_step(input logic [WIDTH-1:0] p,
                                                input logic             msb,
                                                input logic [WIDTH-1:0] d);
    logic [WIDTH:0] sh, diff;
    sh   = {p, msb};
    diff = sh - {1'b0, d};
    if (!diff[WIDTH]) return {1'b1, diff[WIDTH-1:0]};
    else              return {1'b0, sh[WIDTH-1:0]};
  endfunction

  always_comb begin
    step      = trial_step(prem, work[WIDTH-1], dsr);
    prem_next = step[WIDTH-1:0];
    work_next = {work[WIDTH-2:0], step[WIDTH]};
  end

  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (cnt == CW'(1));
  assign busy   = (state == RUN);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ready     <= 1'b0;
      div_zero  <= 1'b0;
      owner     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state <= state_next;
      ready <= last;
      if (accept) begin
        cnt      <= CW'(WIDTH);
        owner    <= sel;
        div_zero <= sel ? (divisor_b == '0) : (divisor_a == '0);
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
      end
      if (last) begin
        quotient  <= work_next;
        remainder <= prem_next;
      end
    end
  end

  // Working datapath: operands are latched once, so inputs may change mid-run.
  always_ff @(posedge clk) begin
    if (accept) begin
      prem <= '0;
      work <= sel ? dividend_b : dividend_a;
      dsr  <= sel ? divisor_b  : divisor_a;
    end else if (state == RUN) begin
      prem <= prem_next;
      work <= work_next;
    end
  end

endmodule

// File: tb/tb_shared_divider.sv
// Directed bench for shared_divider with hand-computed expected results.
module tb_shared_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sel;
  logic [15:0] dividend_a, divisor_a, dividend_b, divisor_b;
  logic [15:0] quotient, remainder;
  logic        busy, ready, div_zero, owner;

  int checks = 0;
  int errors = 0;

  shared_divider #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel),
    .dividend_a(dividend_a), .divisor_a(divisor_a),
    .dividend_b(dividend_b), .divisor_b(divisor_b),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .ready(ready), .div_zero(div_zero), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Issue one start pulse, then count busy cycles until the ready pulse.
  task automatic do_op(input logic s, input logic [15:0] dd, input logic [15:0] ds,
                       input logic exp_dz, output int busy_cnt, output bit got);
    @(negedge clk);
    sel = s;
    if (s) begin dividend_b = dd; divisor_b = ds; end
    else   begin dividend_a = dd; divisor_a = ds; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("dz_after_accept", div_zero, exp_dz);
    busy_cnt = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ready) got = 1;
      else if (busy) busy_cnt++;
    end
  endtask

  task automatic op_check(input string tag, input logic s, input logic [15:0] dd,
                          input logic [15:0] ds, input logic [15:0] eq,
                          input logic [15:0] er, input logic edz);
    int  bc;
    bit  got;
    do_op(s, dd, ds, edz, bc, got);
    check({tag, "_ready"}, got, 1);
    check({tag, "_busy_cycles"}, bc, 16);
    check({tag, "_quot"}, quotient, eq);
    check({tag, "_rem"}, remainder, er);
    check({tag, "_owner"}, owner, s);
    check({tag, "_dz"}, div_zero, edz);
    @(negedge clk);
    check({tag, "_ready_single"}, ready, 0);
  endtask

  initial begin
    int nready, last_t, t, low_cnt, npulse;
    rst = 1'b0; start = 1'b0; sel = 1'b0;
    dividend_a = '0; divisor_a = '0; dividend_b = '0; divisor_b = '0;
    #12;
    check("rst_quot", quotient, 0);
    check("rst_rem", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 0);
    check("rst_dz", div_zero, 0);
    check("rst_owner", owner, 0);
    @(negedge clk); rst = 1'b1;

    op_check("a_1000_7", 1'b0, 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0);
    op_check("b_65535_1", 1'b1, 16'd65535, 16'd1, 16'd65535, 16'd0, 1'b0);
    op_check("b_3_10", 1'b1, 16'd3, 16'd10, 16'd0, 16'd3, 1'b0);
    op_check("a_5_0", 1'b0, 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
    op_check("a_20_4", 1'b0, 16'd20, 16'd4, 16'd5, 16'd0, 1'b0);

    // Start while busy is ignored; operand changes after acceptance have no effect.
    @(negedge clk);
    sel = 1'b0; dividend_a = 16'd1000; divisor_a = 16'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;            // E0
    @(posedge clk); #1; dividend_a = 16'd0;      // before E0+2
    @(posedge clk); @(posedge clk); @(posedge clk); #1;  // after E0+4
    sel = 1'b1; dividend_b = 16'd50; divisor_b = 16'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; sel = 1'b0;       // E0+5
    nready = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ready) nready++;
    end
    check("ign_ready_count", nready, 1);
    check("ign_quot", quotient, 142);
    check("ign_rem", remainder, 6);
    check("ign_owner", owner, 0);
    check("ign_idle", busy, 0);

    // Start held high: back-to-back operations with one idle cycle between.
    @(negedge clk);
    sel = 1'b0; dividend_a = 16'd100; divisor_a = 16'd9; start = 1'b1;
    last_t = -1; npulse = 0; low_cnt = 0;
    for (t = 0; t < 60 && npulse < 3; t++) begin
      @(negedge clk);
      if (npulse >= 1 && !busy) low_cnt++;
      if (ready) begin
        npulse++;
        check("held_quot", quotient, 11);
        check("held_rem", remainder, 1);
        if (last_t >= 0) check("held_period", t - last_t, 17);
        if (npulse == 2) check("held_busy_low", low_cnt, 1);
        last_t = t;
      end
    end
    check("held_pulses", npulse, 3);
    start = 1'b0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    check("held_drain", busy, 0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    sel = 1'b1; dividend_b = 16'd1000; divisor_b = 16'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_quot", quotient, 0);
    check("arst_rem", remainder, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", ready, 0);
    check("arst_owner", owner, 0);
    @(negedge clk); @(negedge clk); rst = 1'b1;
    nready = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (ready || busy) nready++;
    end
    check("arst_quiet", nready, 0);
    op_check("post_rst", 1'b0, 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
